uart_tx: RTL
============

Name: uart_tx

Overview:
Serial UART transmitter, 8N1 by default. It is the transmit end of the serial echo path: the echo controller pulses sttx_i and then waits on eot_o. The block serialises one byte per start request onto tx_o. The frame is LSB first, framed by a start bit and a stop bit, and each bit lasts BAUD_DIV clock cycles.

Parameters:
BAUD_DIV, 5208, clock cycles per serial bit (50 MHz / 9600 baud); legal range >= 2.
DATA_BITS, 8, payload bits per frame; legal range 5..8.

Ports:
clk_i  input  1  system clock.
rst_i  input  1  reset, asynchronous, active-high.
sttx_i  input  1  start-transmission request; one-cycle pulse from the echo controller, sampled on the rising edge.
din_i  input  DATA_BITS  byte to send; sampled only on the accepting edge.
tx_o  output  1  serial line, registered, idle high.
eot_o  output  1  end-of-transmission level; 1 = idle/done, 0 = frame in progress.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - tx_o = 1, eot_o = 1, state = IDLE.
  - Baud counter, bit counter and shift register cleared.
  - No partial frame resumes after reset deasserts.
- States:
  - IDLE: tx_o = 1, eot_o = 1.
    - Edge with sttx_i = 1: latch din_i into the shift register, clear the counters, go to START.
    - From that same edge: tx_o = 0 and eot_o = 0.
  - START: tx_o = 0 for BAUD_DIV cycles, then go to DATA.
  - DATA: tx_o = shift_reg[0].
    - After each BAUD_DIV cycles: shift right and increment the bit counter.
    - After DATA_BITS bits go to STOP (or to PARITY when the optional feature is enabled).
  - STOP: tx_o = 1 for BAUD_DIV cycles.
    - On the edge ending the stop bit: state = IDLE, eot_o = 1.
- Baud counter:
  - Width $clog2(BAUD_DIV).
  - Counts 0..BAUD_DIV-1; the bit boundary is when the counter equals BAUD_DIV-1.
  - Wraps to 0 at each boundary.
  - Resets to 0 on frame accept.
- Bit counter width $clog2(DATA_BITS+1).
- Timing:
  - tx_o falls on the same edge that samples sttx_i = 1.
  - Frame length from tx_o fall to eot_o rise is exactly (DATA_BITS+2)*BAUD_DIV cycles (80 cycles with 8N1 and BAUD_DIV=8, for example).
- Handshake:
  - eot_o is 0 in the cycle after the accepting edge. The controller therefore sees eot_o = 0 when it enters its wait state, and must wait for the rise.
  - sttx_i is accepted only in IDLE. Pulses while eot_o = 0 are ignored and not queued, including a pulse coincident with the last stop-bit cycle.
  - The earliest next accept is the edge after eot_o rises.
- din_i changes after accept do not affect the frame in flight.
- tx_o and eot_o come straight from flops; there is no combinational path from inputs to outputs.
- Any illegal or unused state encoding recovers to IDLE on the next edge, with tx_o = 1 and eot_o = 1.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting BAUD_DIV cycles.
  - tx_o = even parity: the XOR of all DATA_BITS latched bits, computed at accept.
  - Frame length becomes (DATA_BITS+3)*BAUD_DIV cycles.
- Undefined: no PARITY state and no parity logic; the frame is as described in Behaviour.

Test Plan:
1. Reset, BAUD_DIV=4, no stimulus for 20 cycles -> tx_o = 1 and eot_o = 1 throughout; pulsing rst_i mid-idle keeps both at 1.
2. sttx_i pulse with din_i = 0x55 -> bit sequence 0, 1,0,1,0,1,0,1,0, 1 (start, LSB-first data, stop). Each level is held exactly 4 cycles; eot_o = 0 for 40 cycles, then 1.
3. Back-to-back sends of 0x00 then 0xFF, second pulse issued the cycle after eot_o rises -> 0x00 gives 9 low bits then stop; 0xFF gives start then 9 high bits. Both frames are accepted with no gap beyond 1 idle cycle.
4. din_i = 0xA3 sent; sttx_i pulsed again at cycle 10 and at the last stop cycle, with din_i changed to 0x3C -> only one frame is transmitted, carrying 0xA3; eot_o rises once.
5. rst_i asserted at cycle 17 of a 0x81 frame -> tx_o = 1 and eot_o = 1 immediately (asynchronous). After release, a new pulse with 0x42 produces a clean full frame.
6. Build with UART_TX_PARITY_EN, din_i = 0x07 -> parity bit = 1 follows the data bits; frame is 44 cycles. With din_i = 0x03 -> parity bit = 0.

Source files
------------

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- serial UART transmitter (8N1 by default)
//
// Transmit end of the serial echo path. A one-cycle pulse on sttx_i while
// idle latches din_i and sends one frame on tx_o: start bit (0), DATA_BITS
// payload bits LSB first, stop bit (1). Each bit lasts BAUD_DIV clocks.
// eot_o is low for the whole frame and rises on the edge that ends the
// stop bit.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
//
// Parameters:
//   BAUD_DIV  clock cycles per serial bit (>= 2)
//   DATA_BITS payload bits per frame (5..8)
//
// Ports:
//   clk_i   in   system clock
//   rst_i   in   asynchronous active-high reset
//   sttx_i  in   start request pulse, honoured only while idle
//   din_i   in   byte to send, sampled on the accepting edge
//   tx_o    out  serial line, registered, idles high
//   eot_o   out  1 = idle/done, 0 = frame in progress (registered)
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int BAUD_DIV  = 5208,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sttx_i,
    input  logic [DATA_BITS-1:0] din_i,
    output logic                 tx_o,
    output logic                 eot_o
);

    localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic [BAUD_W-1:0]    r_baud_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif
    logic                 w_accept;
    logic                 w_tick;
    logic                 w_busy;
    logic                 w_next_bit;
    logic                 w_tx_next;
    logic                 w_eot_next;

    assign w_accept = (r_state == S_IDLE) && sttx_i;
    assign w_tick   = (r_baud_cnt == BAUD_LAST);

    always_comb begin
        case (r_state)
            S_START, S_DATA, S_STOP: w_busy = 1'b1;
`ifdef UART_TX_PARITY_EN
            S_PARITY:                w_busy = 1'b1;
`endif
            default:                 w_busy = 1'b0;
        endcase
    end

    // Bit that will sit in shift_reg[0] after this edge; tx_o is registered,
    // so it must be chosen from the post-edge value.
    always_comb begin
        if (w_accept)
            w_next_bit = din_i[0];
        else if ((r_state == S_DATA) && w_tick)
            w_next_bit = r_shift[1];
        else
            w_next_bit = r_shift[0];
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic; unused encodings fall back to IDLE
    always_comb begin
        w_state_next = S_IDLE;
        case (r_state)
            S_IDLE:   w_state_next = sttx_i ? S_START : S_IDLE;
            S_START:  w_state_next = w_tick ? S_DATA : S_START;
            S_DATA: begin
                if (w_tick && (r_bit_cnt == BIT_LAST))
`ifdef UART_TX_PARITY_EN
                    w_state_next = S_PARITY;
`else
                    w_state_next = S_STOP;
`endif
                else
                    w_state_next = S_DATA;
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_state_next = w_tick ? S_STOP : S_PARITY;
`endif
            S_STOP:   w_state_next = w_tick ? S_IDLE : S_STOP;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Output logic: line levels for the state being entered, so the
    // registered outputs change on the same edge as the state.
    always_comb begin
        w_tx_next  = 1'b1;
        w_eot_next = 1'b1;
        case (w_state_next)
            S_START: begin
                w_tx_next  = 1'b0;
                w_eot_next = 1'b0;
            end
            S_DATA: begin
                w_tx_next  = w_next_bit;
                w_eot_next = 1'b0;
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                w_tx_next  = r_parity;
                w_eot_next = 1'b0;
            end
`endif
            S_STOP: begin
                w_tx_next  = 1'b1;
                w_eot_next = 1'b0;
            end
            default: begin
                w_tx_next  = 1'b1;
                w_eot_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_o  <= 1'b1;
            eot_o <= 1'b1;
        end else begin
            tx_o  <= w_tx_next;
            eot_o <= w_eot_next;
        end
    end

    // Baud/bit counters and shift register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else if (w_accept) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= din_i;
        end else if (w_busy) begin
            r_baud_cnt <= w_tick ? '0 : r_baud_cnt + 1'b1;
            if ((r_state == S_DATA) && w_tick) begin
                r_shift   <= r_shift >> 1;
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity is fixed at accept so later din_i changes cannot leak in.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_parity <= 1'b0;
        else if (w_accept)
            r_parity <= ^din_i;
    end
`endif

endmodule
